// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified memory port between the multicycle MIPS core (c_*)
// and a DMA/loader master (d_*). Each access takes two cycles: ARB picks a
// winner and registers its address/data, ACC drives the memory and acks the
// owner. Winner selection is round-robin. A DMA burst lock can keep the port
// for up to MAX_BURST back-to-back grants while the CPU waits, and then the
// CPU is forced in.
// Optional feature: define ARB_STATS_EN to enable the 16-bit grant counters on
// cpu_cnt/dma_cnt. Without it both outputs are tied to zero.
module mem_port_arbiter #(
  parameter int N         = 32,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  // CPU master
  input  logic         c_req,
  input  logic         c_we,
  input  logic [N-1:0] c_adr,
  input  logic [N-1:0] c_wd,
  output logic         c_ack,
  output logic [N-1:0] c_rd,
  // DMA master
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_adr,
  input  logic [N-1:0] d_wd,
  input  logic         d_lock,
  output logic         d_ack,
  output logic [N-1:0] d_rd,
  // memory port
  output logic [N-1:0] dataadr,
  output logic [N-1:0] writedata,
  output logic         memwrite,
  input  logic [N-1:0] readdata,
  // grant statistics
  output logic [15:0]  cpu_cnt,
  output logic [15:0]  dma_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic {
    ARB = 1'b0,
    ACC = 1'b1
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  state_t        state, state_nxt;
  owner_t        last;       // most recent grant, drives round-robin
  owner_t        owner;      // master being served in ACC
  owner_t        winner;
  logic          grant;
  logic [BW-1:0] burst, burst_nxt;
  logic          we_q;
  logic          in_acc;
  logic [N-1:0]  c_rd_q, d_rd_q;

  // Next state, winner selection and burst bookkeeping for the ARB cycle.
  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = OWN_CPU;
    burst_nxt = burst;
    case (state)
      ARB: begin
        if (c_req || d_req) begin
          grant     = 1'b1;
          state_nxt = ACC;
          if (c_req && !d_req) begin
            winner = OWN_CPU;
          end else if (!c_req) begin
            winner = OWN_DMA;
          end else if (burst == BURST_MAX) begin
            // lock has used up its budget: CPU is forced in
            winner = OWN_CPU;
          end else if (last == OWN_DMA && d_lock) begin
            // active burst lock keeps the port on the DMA side
            winner = OWN_DMA;
          end else begin
            winner = (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
          end

          if (winner == OWN_CPU || !d_lock) begin
            burst_nxt = '0;
          end else if (c_req && burst != BURST_MAX) begin
            // only grants taken while the CPU waits count against the budget
            burst_nxt = burst + BW'(1);
          end
        end
      end
      ACC:     state_nxt = ARB;
      default: state_nxt = ARB;
    endcase
  end

  // State register; reset mid-access returns to ARB and drops the access.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the winner's request into the memory-side registers on a grant.
  // Without a grant, address and data simply hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dataadr   <= '0;
      writedata <= '0;
      we_q      <= 1'b0;
      owner     <= OWN_CPU;
      last      <= OWN_DMA;
      burst     <= '0;
    end else if (grant) begin
      owner <= winner;
      last  <= winner;
      burst <= burst_nxt;
      if (winner == OWN_DMA) begin
        dataadr   <= d_adr;
        writedata <= d_wd;
        we_q      <= d_we;
      end else begin
        dataadr   <= c_adr;
        writedata <= c_wd;
        we_q      <= c_we;
      end
    end
  end

  // ACC-cycle strobes decode straight from registered state, so an async
  // reset removes them immediately.
  assign in_acc   = (state == ACC);
  assign memwrite = in_acc && we_q;
  assign c_ack    = in_acc && (owner == OWN_CPU);
  assign d_ack    = in_acc && (owner == OWN_DMA);

  // Read data holders: the owner sees readdata live in its ack cycle, the
  // other master keeps whatever it received last.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_rd_q <= '0;
      d_rd_q <= '0;
    end else begin
      if (c_ack) c_rd_q <= readdata;
      if (d_ack) d_rd_q <= readdata;
    end
  end

  assign c_rd = c_ack ? readdata : c_rd_q;
  assign d_rd = d_ack ? readdata : d_rd_q;

`ifdef ARB_STATS_EN
  logic [15:0] cpu_cnt_q, dma_cnt_q;

  // Grant counters, one per master, wrapping at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_cnt_q <= '0;
      dma_cnt_q <= '0;
    end else begin
      if (c_ack) cpu_cnt_q <= cpu_cnt_q + 16'd1;
      if (d_ack) dma_cnt_q <= dma_cnt_q + 16'd1;
    end
  end

  assign cpu_cnt = cpu_cnt_q;
  assign dma_cnt = dma_cnt_q;
`else
  assign cpu_cnt = '0;
  assign dma_cnt = '0;
`endif

endmodule
